// File: rtl/vga_timing_monitor.sv
// VGA timing monitor: measures line/frame timing from rgb/hs/vs, declares lock, signs each frame.
// Define VGA_MON_CRC_EN for a CRC-16-CCITT frame signature instead of a 16-bit wrapping sum.
module vga_timing_monitor #(
    parameter int unsigned RGB_W       = 12,
    parameter int unsigned CNT_W       = 12,
    parameter bit          SYNC_POL    = 1'b0,
    parameter int unsigned LOCK_FRAMES = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [RGB_W-1:0] vga_rgb_i,
    input  logic             vga_hs_i,
    input  logic             vga_vs_i,
    output logic [CNT_W-1:0] h_total_o,
    output logic [CNT_W-1:0] hs_width_o,
    output logic [CNT_W-1:0] v_total_o,
    output logic [CNT_W-1:0] vs_width_o,
    output logic             frame_done_o,
    output logic [15:0]      frame_sig_o,
    output logic             locked_o,
    output logic             lock_lost_o,
    output logic [7:0]       lost_cnt_o
);

    localparam logic [3:0] LockFrames = 4'(LOCK_FRAMES);
`ifdef VGA_MON_CRC_EN
    localparam logic [15:0] SigInit = 16'hFFFF;
`else
    localparam logic [15:0] SigInit = 16'h0000;
`endif

    typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_e;

    function automatic logic [15:0] sig_step(input logic [15:0] acc, input logic [RGB_W-1:0] d);
`ifdef VGA_MON_CRC_EN
        logic [15:0] c;
        c = acc;
        for (int i = RGB_W - 1; i >= 0; i--) begin
            c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        end
        return c;
`else
        return acc + 16'(d);
`endif
    endfunction

    logic [RGB_W-1:0]   r_rgb;
    logic               r_hs, r_vs, r_hs_d, r_vs_d;
    logic [CNT_W-1:0]   r_hc, r_hsw, r_vc, r_vsw;
    logic [CNT_W-1:0]   r_h_total, r_hs_width, r_v_total, r_vs_width;
    logic [15:0]        r_sig, r_frame_sig;
    logic               r_frame_done;
    state_e             r_state;
    logic [3:0]         r_match;
    logic [3*CNT_W-1:0] r_tuple;
    logic               r_locked, r_lock_lost;
    logic [7:0]         r_lost_cnt;

    logic               w_hs_edge, w_hs_trail, w_vs_edge, w_vs_trail;
    logic               w_sat, w_hs_bad, w_tuple_eq;
    logic [3*CNT_W-1:0] w_tuple;

    assign w_hs_edge  = r_hs & ~r_hs_d;
    assign w_hs_trail = ~r_hs & r_hs_d;
    assign w_vs_edge  = r_vs & ~r_vs_d;
    assign w_vs_trail = ~r_vs & r_vs_d;
    assign w_sat      = (&r_hc) | (&r_vc);
    assign w_hs_bad   = w_hs_edge & (r_hc != r_h_total);
    // Compare against the values being latched this cycle, not the stale registers.
    assign w_tuple    = {(w_hs_edge ? r_hc : r_h_total), (w_hs_trail ? r_hsw : r_hs_width), r_vc};
    assign w_tuple_eq = (w_tuple == r_tuple);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rgb  <= '0;
            r_hs   <= 1'b0;
            r_vs   <= 1'b0;
            r_hs_d <= 1'b0;
            r_vs_d <= 1'b0;
        end else begin
            r_rgb  <= vga_rgb_i;
            r_hs   <= vga_hs_i ~^ SYNC_POL;
            r_vs   <= vga_vs_i ~^ SYNC_POL;
            r_hs_d <= r_hs;
            r_vs_d <= r_vs;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hc         <= '0;
            r_hsw        <= '0;
            r_vc         <= '0;
            r_vsw        <= '0;
            r_h_total    <= '0;
            r_hs_width   <= '0;
            r_v_total    <= '0;
            r_vs_width   <= '0;
            r_sig        <= SigInit;
            r_frame_sig  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_vs_edge;

            if (w_hs_edge) begin
                r_h_total <= r_hc;
                r_hc      <= CNT_W'(1);
            end else if (!(&r_hc)) begin
                r_hc <= r_hc + CNT_W'(1);
            end

            if (w_hs_trail) begin
                r_hs_width <= r_hsw;
                r_hsw      <= '0;
            end else if (r_hs && !(&r_hsw)) begin
                r_hsw <= r_hsw + CNT_W'(1);
            end

            // A coincident HS edge is the first line of the new frame.
            if (w_vs_edge) begin
                r_v_total <= r_vc;
                r_vc      <= w_hs_edge ? CNT_W'(1) : '0;
            end else if (w_hs_edge && !(&r_vc)) begin
                r_vc <= r_vc + CNT_W'(1);
            end

            if (w_vs_trail) begin
                r_vs_width <= r_vsw;
                r_vsw      <= '0;
            end else if (w_hs_edge && r_vs && !(&r_vsw)) begin
                r_vsw <= r_vsw + CNT_W'(1);
            end

            if (w_vs_edge) begin
                r_frame_sig <= r_sig;
                r_sig       <= sig_step(SigInit, r_rgb);
            end else begin
                r_sig <= sig_step(r_sig, r_rgb);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= StSearch;
            r_match     <= '0;
            r_tuple     <= '0;
            r_locked    <= 1'b0;
            r_lock_lost <= 1'b0;
            r_lost_cnt  <= '0;
        end else begin
            r_lock_lost <= 1'b0;
            if (w_vs_edge) begin
                r_tuple <= w_tuple;
            end
            unique case (r_state)
                StSearch: begin
                    if (w_sat) begin
                        r_match <= '0;
                    end
                    if (w_vs_edge) begin
                        r_state <= StMeasure;
                        r_match <= '0;
                    end
                end
                StMeasure: begin
                    if (w_sat) begin
                        r_match <= '0;
                    end else if (w_vs_edge) begin
                        if (!w_tuple_eq) begin
                            r_match <= '0;
                        end else if (r_match + 4'd1 >= LockFrames) begin
                            r_match  <= LockFrames;
                            r_state  <= StLocked;
                            r_locked <= 1'b1;
                        end else begin
                            r_match <= r_match + 4'd1;
                        end
                    end
                end
                StLocked: begin
                    if (w_sat || w_hs_bad || (w_vs_edge && !w_tuple_eq)) begin
                        r_state     <= StMeasure;
                        r_match     <= '0;
                        r_locked    <= 1'b0;
                        r_lock_lost <= 1'b1;
                        if (r_lost_cnt != 8'hFF) begin
                            r_lost_cnt <= r_lost_cnt + 8'd1;
                        end
                    end
                end
                default: r_state <= StSearch;
            endcase
        end
    end

    assign h_total_o    = r_h_total;
    assign hs_width_o   = r_hs_width;
    assign v_total_o    = r_v_total;
    assign vs_width_o   = r_vs_width;
    assign frame_done_o = r_frame_done;
    assign frame_sig_o  = r_frame_sig;
    assign locked_o     = r_locked;
    assign lock_lost_o  = r_lock_lost;
    assign lost_cnt_o   = r_lost_cnt;

endmodule
